stage3_split_lsu: RTL
=====================

// Module: stage3_split_lsu
// PURPOSE
// Parametrised load/store unit for the stage3 memory stage. Generalises byte-enable generation,
// store lane replication and load extension to XLEN 32/64 and optional big-endian lane order.
// When enabled, it splits misaligned accesses into two aligned generic-bus beats; otherwise it
// flags them as misaligned. It sits between the ex/mem pipeline register and the data generic bus.
// PARAMETERS
// XLEN      32   data/address width, 32 or 64; NB = XLEN/8 byte lanes, OW = log2(NB)
// SPLIT_EN  1    1: split misaligned accesses into two beats; 0: raise mal_fault
// BIG_END   0    1: reverse the lane order of bus_byte_en, bus_wdata and bus_rdata
// PORTS
// CLK          in   1      clock, rising edge
// RST          in   1      reset, asynchronous, active-high
// req_ren      in   1      load request; held stable by the pipeline until done
// req_wen      in   1      store request; same hold rule
// req_type     in   3      funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
// req_addr     in   XLEN   byte address
// req_wdata    in   XLEN   store data, right-justified
// suppress     in   1      blocks acceptance in IDLE (flush/exception); no effect after accept
// busy_o       out  1      stall request to hazard unit
// done         out  1      1-cycle pulse: access complete
// rdata_o      out  XLEN   extended load result; valid only while done=1
// mal_fault    out  1      1-cycle pulse: misaligned access with SPLIT_EN=0
// size_err     out  1      1-cycle pulse: D/WU request with XLEN=32
// bus_addr     out  XLEN   lane-aligned beat address (low OW bits are 0)
// bus_ren      out  1      generic bus read
// bus_wen      out  1      generic bus write
// bus_byte_en  out  NB     lane enables
// bus_wdata    out  XLEN   lane-positioned store data
// bus_rdata    in   XLEN   read data; sampled when bus_busy=0
// bus_busy     in   1      a beat completes in any cycle where ren|wen=1 and bus_busy=0
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; the hold register is cleared. Reset asserted mid-access
//   deasserts bus_ren/bus_wen immediately and drops the access; no done pulse is produced.
// - Width: W = 2^type[1:0] bytes; off = addr[OW-1:0]; misaligned when off mod W != 0.
//   Split when off+W > NB, else single beat. Aligned W=NB is never split.
// - FSM states: IDLE, FIRST, SECOND.
// - IDLE, (ren|wen)&!suppress:
//   - size_err case: pulse size_err, stay in IDLE.
//   - misaligned with SPLIT_EN=0: pulse mal_fault, stay in IDLE.
//   - otherwise: latch the request, go to FIRST. busy_o=1 in this cycle. No bus activity in IDLE.
//   - ren and wen both set: treated as a load.
// - FIRST: drive beat0 with addr = {addr[XLEN-1:OW], 0} and byte_en = lanes off..min(off+W,NB)-1.
//   - Beat completes on a single-beat access: done=1, busy_o=0, go to IDLE.
//   - Beat completes on a split access: capture bus_rdata in the hold register, go to SECOND,
//     busy_o=1.
// - SECOND: addr = beat0 addr + NB (wraps modulo 2^XLEN); byte_en = lanes 0..off+W-NB-1.
//   On completion: done=1, busy_o=0, go to IDLE.
// - busy_o=1 from the accept cycle through every bus wait cycle; it is 0 in the done cycle.
//   Minimum latency with a zero-wait bus: 2 cycles single-beat, 3 cycles split.
// - Store data: beat0 wdata = (req_wdata << 8*off) truncated to XLEN.
//   Beat1 wdata = req_wdata >> 8*(NB-off). Lanes without enables are driven to 0.
// - Load data: {beat1_rdata, hold} >> 8*off (single beat: bus_rdata >> 8*off).
//   Take the low W bytes, sign-extend for B/H/W (W sign-extends only at XLEN=64),
//   zero-extend for BU/HU/WU/D.
// - BIG_END=1: lane i maps to bus lane NB-1-i for byte_en, wdata and rdata; addressing is unchanged.
// - Request inputs are registered at accept; input changes during FIRST/SECOND are ignored.
// TESTING
// 1. XLEN=32, LW 0x100, zero-wait, rdata 0xDEADBEEF -> one beat, addr 0x100, be 0xF,
//    done at cycle 2, rdata_o 0xDEADBEEF.
// 2. LB 0x103, rdata 0x80000000 -> be 4'b1000, rdata_o 0xFFFFFF80; LBU -> 0x00000080.
// 3. SPLIT_EN=1, LW 0x102, beat0 busy held for 3 cycles, rdata 0x22110000 -> beat0 addr 0x100,
//    be 1100; beat1 addr 0x104, be 0011, rdata 0x00004433 -> rdata_o 0x44332211; busy_o=1 until done.
// 4. SH 0x103, wdata 0xABCD -> beat0 addr 0x100, be 1000, wdata 0xCD000000;
//    beat1 addr 0x104, be 0001, wdata 0x000000AB.
// 5. SPLIT_EN=0, LW 0x101 -> mal_fault pulses once, bus_ren never rises, busy_o stays 0;
//    XLEN=32, LD -> size_err pulses once.
// 6. RST asserted in SECOND with bus_busy=1 -> bus_ren=0 in the same cycle, busy_o=0, no done;
//    a fresh LW after release completes normally.

Source files
------------

// File: rtl/stage3_split_lsu.sv
// -----------------------------------------------------------------------------
// stage3_split_lsu
//
// Load/store unit for the stage3 memory stage. It sits between the ex/mem
// pipeline register and the data generic bus. It generates byte enables,
// positions store data on the bus lanes and extends load results for
// XLEN 32 or 64, with optional big-endian lane order. Misaligned accesses
// are either split into two aligned bus beats (SPLIT_EN=1) or reported
// through mal_fault (SPLIT_EN=0).
//
// Parameters
//   XLEN      data/address width (32 or 64); NB = XLEN/8 lanes
//   SPLIT_EN  1: split lane-crossing accesses into two beats, 0: fault
//   BIG_END   1: reverse lane order of bus_byte_en, bus_wdata, bus_rdata
//
// Ports
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   req_ren/req_wen     load/store request, held until done
//   req_type            funct3 (B/H/W/D/BU/HU/WU)
//   req_addr/req_wdata  byte address, right-justified store data
//   suppress            blocks acceptance of a new request
//   busy_o              stall request to the hazard unit
//   done                1-cycle completion pulse, rdata_o valid with it
//   mal_fault/size_err  1-cycle fault pulses, request not accepted
//   bus_*               generic data bus master side
// -----------------------------------------------------------------------------
module stage3_split_lsu #(
    parameter int XLEN     = 32,
    parameter bit SPLIT_EN = 1'b1,
    parameter bit BIG_END  = 1'b0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 req_ren,
    input  logic                 req_wen,
    input  logic [2:0]           req_type,
    input  logic [XLEN-1:0]      req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    input  logic                 suppress,
    output logic                 busy_o,
    output logic                 done,
    output logic [XLEN-1:0]      rdata_o,
    output logic                 mal_fault,
    output logic                 size_err,
    output logic [XLEN-1:0]      bus_addr,
    output logic                 bus_ren,
    output logic                 bus_wen,
    output logic [XLEN/8-1:0]    bus_byte_en,
    output logic [XLEN-1:0]      bus_wdata,
    input  logic [XLEN-1:0]      bus_rdata,
    input  logic                 bus_busy
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam int SW = OW + 4;
    localparam logic [4:0] NB_C = 5'(NB);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_t;

    state_t state, state_nxt;

    // latched request
    logic [2:0]      type_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic            load_q;
    // logical-lane read data of beat0 of a split load
    logic [XLEN-1:0] hold_q;

    logic accept;
    logic capture;

    // ------------------------------------------------------------------
    // helper functions
    // ------------------------------------------------------------------
    function automatic logic [4:0] width_bytes(input logic [2:0] t);
        return 5'd1 << t[1:0];
    endfunction

    function automatic logic is_misaligned(input logic [2:0] t, input logic [OW-1:0] off);
        logic [4:0] o;
        o = 5'(off);
        return |(o & (width_bytes(t) - 5'd1));
    endfunction

    function automatic logic is_size_err(input logic [2:0] t);
        return (XLEN == 32) && ((t[1:0] == 2'b11) || (t == 3'b110));
    endfunction

    function automatic logic [XLEN-1:0] swap_lanes(input logic [XLEN-1:0] d);
        logic [XLEN-1:0] r;
        r = '0;
        for (int i = 0; i < NB; i++) begin
            r[8*i +: 8] = d[8*(NB-1-i) +: 8];
        end
        return r;
    endfunction

    function automatic logic [NB-1:0] swap_be(input logic [NB-1:0] b);
        logic [NB-1:0] r;
        r = '0;
        for (int i = 0; i < NB; i++) begin
            r[i] = b[NB-1-i];
        end
        return r;
    endfunction

    function automatic logic [XLEN-1:0] mask_lanes(input logic [XLEN-1:0] d,
                                                   input logic [NB-1:0]   be);
        logic [XLEN-1:0] r;
        r = '0;
        for (int i = 0; i < NB; i++) begin
            r[8*i +: 8] = be[i] ? d[8*i +: 8] : 8'h00;
        end
        return r;
    endfunction

    // W sign-extends to the full register; at XLEN=32 that is a no-op.
    function automatic logic [XLEN-1:0] load_extend(input logic [2:0]      t,
                                                    input logic [XLEN-1:0] d);
        logic [XLEN-1:0] r;
        r = d;
        case (t)
            3'b000: begin r = {XLEN{d[7]}};  r[7:0]  = d[7:0];  end
            3'b001: begin r = {XLEN{d[15]}}; r[15:0] = d[15:0]; end
            3'b010: begin r = {XLEN{d[31]}}; r[31:0] = d[31:0]; end
            3'b100: begin r = '0;            r[7:0]  = d[7:0];  end
            3'b101: begin r = '0;            r[15:0] = d[15:0]; end
            3'b110: begin r = '0;            r[31:0] = d[31:0]; end
            default: r = d;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // decode of the incoming request (used only in IDLE)
    // ------------------------------------------------------------------
    logic            req_any;
    logic            in_size_err;
    logic            in_mal;

    // RST gating keeps every output at 0 while reset is held.
    assign req_any     = (req_ren | req_wen) & ~suppress & ~RST;
    assign in_size_err = is_size_err(req_type);
    assign in_mal      = !SPLIT_EN && is_misaligned(req_type, req_addr[OW-1:0]);

    // ------------------------------------------------------------------
    // decode of the latched request
    // ------------------------------------------------------------------
    logic [OW-1:0]   off_q;
    logic [4:0]      off5_q;
    logic [4:0]      end_q;
    logic            cross_q;
    logic [XLEN-1:0] beat0_addr;
    logic [XLEN-1:0] beat1_addr;
    logic [SW-1:0]   sh0;
    logic [SW-1:0]   sh1;
    logic [NB-1:0]   be0_l;
    logic [NB-1:0]   be1_l;
    logic [XLEN-1:0] wdata0_l;
    logic [XLEN-1:0] wdata1_l;
    logic [XLEN-1:0] rdata_l;
    logic [2*XLEN-1:0] merged;
    logic [XLEN-1:0] load_result;

    assign off_q      = addr_q[OW-1:0];
    assign off5_q     = 5'(off_q);
    assign end_q      = off5_q + width_bytes(type_q);
    assign cross_q    = end_q > NB_C;
    assign beat0_addr = {addr_q[XLEN-1:OW], {OW{1'b0}}};
    assign beat1_addr = beat0_addr + XLEN'(NB);
    assign sh0        = SW'({off_q, 3'b000});
    assign sh1        = SW'(8 * NB) - sh0;

    always_comb begin
        be0_l = '0;
        be1_l = '0;
        for (int i = 0; i < NB; i++) begin
            be0_l[i] = (5'(i) >= off5_q) && (5'(i) < end_q);
            be1_l[i] = cross_q && (5'(i + NB) < end_q);
        end
    end

    assign wdata0_l = mask_lanes(wdata_q << sh0, be0_l);
    assign wdata1_l = mask_lanes(wdata_q >> sh1, be1_l);

    // Loads are assembled in logical lane order: beat1 above beat0, then
    // shifted down by the offset.
    assign rdata_l     = BIG_END ? swap_lanes(bus_rdata) : bus_rdata;
    assign merged      = (state == SECOND) ? {rdata_l, hold_q} : {{XLEN{1'b0}}, rdata_l};
    assign load_result = load_extend(type_q, XLEN'(merged >> sh0));

    // ------------------------------------------------------------------
    // state and hold register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            hold_q <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                hold_q <= rdata_l;
            end
        end
    end

    // request capture; contents are only consumed after an accept
    always_ff @(posedge CLK) begin
        if (accept) begin
            type_q  <= req_type;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            load_q  <= req_ren;
        end
    end

    // ------------------------------------------------------------------
    // next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        capture     = 1'b0;
        busy_o      = 1'b0;
        done        = 1'b0;
        rdata_o     = '0;
        mal_fault   = 1'b0;
        size_err    = 1'b0;
        bus_addr    = '0;
        bus_ren     = 1'b0;
        bus_wen     = 1'b0;
        bus_byte_en = '0;
        bus_wdata   = '0;

        case (state)
            IDLE: begin
                if (req_any) begin
                    if (in_size_err) begin
                        size_err = 1'b1;
                    end else if (in_mal) begin
                        mal_fault = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        busy_o    = 1'b1;
                        state_nxt = FIRST;
                    end
                end
            end

            FIRST: begin
                bus_addr    = beat0_addr;
                bus_ren     = load_q;
                bus_wen     = ~load_q;
                bus_byte_en = BIG_END ? swap_be(be0_l) : be0_l;
                if (!load_q) begin
                    bus_wdata = BIG_END ? swap_lanes(wdata0_l) : wdata0_l;
                end
                busy_o = 1'b1;
                if (!bus_busy) begin
                    if (cross_q) begin
                        capture   = load_q;
                        state_nxt = SECOND;
                    end else begin
                        busy_o    = 1'b0;
                        done      = 1'b1;
                        rdata_o   = load_q ? load_result : '0;
                        state_nxt = IDLE;
                    end
                end
            end

            SECOND: begin
                bus_addr    = beat1_addr;
                bus_ren     = load_q;
                bus_wen     = ~load_q;
                bus_byte_en = BIG_END ? swap_be(be1_l) : be1_l;
                if (!load_q) begin
                    bus_wdata = BIG_END ? swap_lanes(wdata1_l) : wdata1_l;
                end
                busy_o = 1'b1;
                if (!bus_busy) begin
                    busy_o    = 1'b0;
                    done      = 1'b1;
                    rdata_o   = load_q ? load_result : '0;
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
